// File: rtl/scp_uart_pkg.sv
// ---------------------------------------------------------------------------
// scp_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - word offsets of the registers inside the 16-byte window (addr[3:2])
//   - bit positions of the STATUS register fields
//   - transmitter FSM state encoding
//   - width of the baud divider
// No ports; imported by mmio_uart_tx.
// ---------------------------------------------------------------------------
package scp_uart_pkg;

   // Width of the clocks-per-bit divider and of the bit timer.
   localparam int DIV_W = 16;

   // Register word offsets (addr[3:2]); offset 3 is reserved.
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;

   // STATUS bit positions.
   localparam int STAT_FULL      = 0;
   localparam int STAT_EMPTY     = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_OVF       = 3;
   localparam int STAT_PARITY    = 4;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_W   = 4;

   // Transmitter states; PARITY is only reachable in the parity build.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy counter. A push while full and a pop
// while empty are ignored; pointers wrap modulo DEPTH (power of two).
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (empties the FIFO)
//   push   in   write din at the tail
//   din    in   WIDTH-bit write data
//   pop    in   discard the head entry
//   dout   out  head entry (valid when not empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  number of stored entries, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign full     = (r_count == FULL_COUNT);
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign dout     = r_mem[r_rdPtr];
   assign w_doPush = push & ~full;
   assign w_doPop  = pop & ~empty;

   // Pointer and occupancy bookkeeping; a simultaneous push and pop
   // leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: an empty FIFO never exposes stale entries.
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= din;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the core's data-memory bus. Stores to
// TXDATA queue bytes in a FIFO; the FSM sends them as 8N1 frames on tx.
// Register window (addr[3:2]): 0 TXDATA (wo), 1 STATUS, 2 BAUDDIV (rw),
// 3 reserved. Loads answer combinationally in the same cycle.
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit and reports it in STATUS bit4.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   cs       in   access strobe for this window
//   wr       in   1 = store, 0 = load
//   mask     in   byte-lane enables
//   addr     in   byte address (only [3:2] decoded here)
//   data_wr  in   store data
//   data_rd  out  load data, 0 unless a load hits this window
//   tx       out  serial output, idle high
//   busy     out  frame in progress or FIFO not empty
// ---------------------------------------------------------------------------
module mmio_uart_tx
   import scp_uart_pkg::*;
#(
   parameter int               FIFO_DEPTH  = 8,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd868,
   parameter logic [31:0]      BASE_ADDR   = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        wr,
   input  logic [3:0]  mask,
   input  logic [31:0] addr,
   input  logic [31:0] data_wr,
   output logic [31:0] data_rd,
   output logic        tx,
   output logic        busy
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   uart_tx_state_t   r_state;
   logic [7:0]       r_shift;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_timer;
   logic [2:0]       r_bitIdx;
   logic [DIV_W-1:0] r_baudDiv;
   logic             r_overflow;

   logic             w_wrEn;
   logic             w_rdEn;
   logic [1:0]       w_reg;
   logic             w_pushReq;
   logic             w_pop;
   logic             w_ovfClr;
   logic             w_divWr;
   logic [DIV_W-1:0] w_divMerged;
   logic [DIV_W-1:0] w_divNext;
   logic             w_timerDone;
   logic [7:0]       w_fifoDout;
   logic             w_fifoFull;
   logic             w_fifoEmpty;
   logic [CNT_W-1:0] w_fifoCount;
   logic [31:0]      w_status;
   logic [31:0]      w_rdData;
   logic             w_tx;
   logic             w_unused;

   assign w_wrEn      = cs & wr;
   assign w_rdEn      = cs & ~wr;
   assign w_reg       = addr[3:2];
   assign w_pushReq   = w_wrEn & (w_reg == REG_TXDATA) & mask[0];
   assign w_ovfClr    = w_wrEn & (w_reg == REG_STATUS) & mask[0] & data_wr[STAT_OVF];
   assign w_divWr     = w_wrEn & (w_reg == REG_BAUDDIV);
   assign w_pop       = (r_state == IDLE) & ~w_fifoEmpty;
   assign w_timerDone = (r_timer == '0);

   // The window base is decoded by the system address map, not here.
   assign w_unused = ^{addr[31:4], addr[1:0], mask[3:2], data_wr[31:16], BASE_ADDR};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_pushReq),
      .din   (data_wr[7:0]),
      .pop   (w_pop),
      .dout  (w_fifoDout),
      .full  (w_fifoFull),
      .empty (w_fifoEmpty),
      .count (w_fifoCount)
   );

   // Byte-lane merge for BAUDDIV; a zero divisor would stall the bit
   // timer, so it is forced to one.
   always_comb begin
      w_divMerged = r_baudDiv;
      if (mask[0]) w_divMerged[7:0]  = data_wr[7:0];
      if (mask[1]) w_divMerged[15:8] = data_wr[15:8];
      w_divNext = (w_divMerged == '0) ? DIV_W'(1) : w_divMerged;
   end

   // Software-visible registers. The overflow flag uses the FIFO's
   // pre-edge fullness, so a same-cycle pop does not save the byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baudDiv  <= DEFAULT_DIV;
         r_overflow <= 1'b0;
      end else begin
         if (w_divWr) r_baudDiv <= w_divNext;
         if (w_pushReq && w_fifoFull) r_overflow <= 1'b1;
         else if (w_ovfClr)           r_overflow <= 1'b0;
      end
   end

   // Transmit FSM. The divider is copied into r_div at frame start so a
   // BAUDDIV write mid-frame only affects the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_div    <= DEFAULT_DIV;
         r_timer  <= '0;
         r_bitIdx <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_fifoEmpty) begin
                  r_shift <= w_fifoDout;
                  r_div   <= r_baudDiv;
                  r_timer <= r_baudDiv - 1'b1;
                  r_state <= START;
               end
            end
            START: begin
               if (w_timerDone) begin
                  r_timer  <= r_div - 1'b1;
                  r_bitIdx <= '0;
                  r_state  <= DATA;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
            DATA: begin
               if (w_timerDone) begin
                  r_timer <= r_div - 1'b1;
                  if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end else begin
                     r_bitIdx <= r_bitIdx + 1'b1;
                  end
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_timerDone) begin
                  r_timer <= r_div - 1'b1;
                  r_state <= STOP;
               end else begin
                  r_timer <= r_timer - 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_timerDone) r_state <= IDLE;
               else             r_timer <= r_timer - 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Line level decoded straight from registered state so that an
   // asynchronous reset returns tx high without waiting for a clock.
   always_comb begin
      w_tx = 1'b1;
      case (r_state)
         START:  w_tx = 1'b0;
         DATA:   w_tx = r_shift[r_bitIdx];
`ifdef UART_TX_PARITY_EN
         PARITY: w_tx = ^r_shift;
`endif
         default: w_tx = 1'b1;
      endcase
   end

   assign tx   = w_tx;
   assign busy = (r_state != IDLE) | ~w_fifoEmpty;

   // STATUS word assembly.
   always_comb begin
      w_status = '0;
      w_status[STAT_FULL]  = w_fifoFull;
      w_status[STAT_EMPTY] = w_fifoEmpty;
      w_status[STAT_BUSY]  = busy;
      w_status[STAT_OVF]   = r_overflow;
`ifdef UART_TX_PARITY_EN
      w_status[STAT_PARITY] = 1'b1;
`endif
      w_status[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_fifoCount);
   end

   // Load data path; anything other than a load to STATUS/BAUDDIV reads 0.
   always_comb begin
      w_rdData = '0;
      if (w_rdEn) begin
         case (w_reg)
            REG_STATUS:  w_rdData = w_status;
            REG_BAUDDIV: w_rdData = {16'b0, r_baudDiv};
            default:     w_rdData = '0;
         endcase
      end
   end

   assign data_rd = w_rdData;

endmodule
